// File: rtl/lookup_scheduler.sv
// Round-robin scheduler sharing one fixed-latency lookup engine between header-parser requesters,
// with requester-ID tracking through the engine and a pause/drain handshake for reconfiguration.

typedef struct packed {
  logic        valid;
  logic [7:0]  port;
  logic [15:0] ethertype;
  logic [47:0] dmac;
  logic [47:0] smac;
} tuple_t;

module lookup_scheduler #(
  parameter int unsigned C_NUM_REQ          = 6,
  parameter int unsigned C_LOOKUP_LATENCY   = 1,
  parameter int unsigned C_OUT_PORT_WIDTH   = 8,
  parameter int unsigned C_MATCH_ADDR_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [C_NUM_REQ-1:0]          req_valid,
  output logic [C_NUM_REQ-1:0]          req_ready,
  input  tuple_t [C_NUM_REQ-1:0]        req_tuple,
  output tuple_t                        lu_tuple,
  input  logic                          lu_action_match,
  input  logic                          lu_action_valid,
  input  logic [C_OUT_PORT_WIDTH-1:0]   lu_action_port,
  input  logic [C_OUT_PORT_WIDTH-1:0]   lu_action_vport,
  input  logic [1:0]                    lu_action_type,
  input  logic [C_MATCH_ADDR_WIDTH-1:0] lu_action_match_addr,
  output logic [C_NUM_REQ-1:0]          rsp_valid,
  output logic                          rsp_match,
  output logic [C_OUT_PORT_WIDTH-1:0]   rsp_port,
  output logic [C_OUT_PORT_WIDTH-1:0]   rsp_vport,
  output logic [1:0]                    rsp_type,
  output logic [C_MATCH_ADDR_WIDTH-1:0] rsp_match_addr,
  input  logic                          cfg_pause,
  output logic                          pause_ack,
  input  logic                          err_clear,
  output logic                          err_unexpected,
  output logic                          err_missing,
  output logic [31:0]                   stat_issued
);

  localparam int unsigned IdW = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;

  typedef enum logic [1:0] {StRun, StDrain, StPaused} state_e;

  state_e                                state_q;
  logic                                  pause_ack_q;
  logic [IdW-1:0]                        rr_ptr_q;
  logic [IdW-1:0]                        grant_idx;
  logic [IdW-1:0]                        scan_idx;
  logic                                  found;
  logic                                  grant_en;
  tuple_t                                issue_tuple;
  tuple_t                                lu_tuple_q;
  logic [IdW-1:0]                        issue_id_q;
  logic [C_LOOKUP_LATENCY-1:0]           pipe_vld_q;
  logic [C_LOOKUP_LATENCY-1:0][IdW-1:0]  pipe_id_q;
  logic                                  tail_vld;
  logic [IdW-1:0]                        tail_id;
  logic [C_NUM_REQ-1:0]                  rsp_valid_q;
  logic                                  rsp_match_q;
  logic [C_OUT_PORT_WIDTH-1:0]           rsp_port_q;
  logic [C_OUT_PORT_WIDTH-1:0]           rsp_vport_q;
  logic [1:0]                            rsp_type_q;
  logic [C_MATCH_ADDR_WIDTH-1:0]         rsp_match_addr_q;
  logic                                  err_unexpected_q;
  logic                                  err_missing_q;
  logic [31:0]                           stat_issued_q;
  logic                                  drained;

  // First valid requester scanning upward from the slot after the last grant.
  always_comb begin
    found     = 1'b0;
    grant_idx = rr_ptr_q;
    scan_idx  = rr_ptr_q;
    for (int unsigned k = 1; k <= C_NUM_REQ; k++) begin
      scan_idx = IdW'((32'(rr_ptr_q) + k) % C_NUM_REQ);
      if (!found && req_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
    grant_en  = reset && (state_q == StRun) && !cfg_pause && found;
    req_ready = '0;
    if (grant_en) req_ready[grant_idx] = 1'b1;
    issue_tuple       = req_tuple[grant_idx];
    issue_tuple.valid = 1'b1;
  end

  assign tail_vld = pipe_vld_q[C_LOOKUP_LATENCY-1];
  assign tail_id  = pipe_id_q[C_LOOKUP_LATENCY-1];
  assign drained  = !lu_tuple_q.valid && !(|pipe_vld_q) && !(|rsp_valid_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q         <= IdW'(C_NUM_REQ - 1);
      lu_tuple_q       <= '0;
      issue_id_q       <= '0;
      pipe_vld_q       <= '0;
      pipe_id_q        <= '0;
      rsp_valid_q      <= '0;
      rsp_match_q      <= 1'b0;
      rsp_port_q       <= '0;
      rsp_vport_q      <= '0;
      rsp_type_q       <= '0;
      rsp_match_addr_q <= '0;
      err_unexpected_q <= 1'b0;
      err_missing_q    <= 1'b0;
      stat_issued_q    <= '0;
    end else begin
      if (grant_en) begin
        rr_ptr_q      <= grant_idx;
        lu_tuple_q    <= issue_tuple;
        issue_id_q    <= grant_idx;
        stat_issued_q <= stat_issued_q + 32'd1;
      end else begin
        lu_tuple_q.valid <= 1'b0;
      end
      // ID pipeline advances with the engine so its tail meets lu_action_valid.
      pipe_vld_q[0] <= lu_tuple_q.valid;
      pipe_id_q[0]  <= issue_id_q;
      for (int unsigned i = 1; i < C_LOOKUP_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
      end
      rsp_valid_q <= '0;
      if (tail_vld && lu_action_valid) begin
        rsp_valid_q[tail_id] <= 1'b1;
        rsp_match_q          <= lu_action_match;
        rsp_port_q           <= lu_action_port;
        rsp_vport_q          <= lu_action_vport;
        rsp_type_q           <= lu_action_type;
        rsp_match_addr_q     <= lu_action_match_addr;
      end
      err_unexpected_q <= (!tail_vld && lu_action_valid) || (err_unexpected_q && !err_clear);
      err_missing_q    <= (tail_vld && !lu_action_valid) || (err_missing_q && !err_clear);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      pause_ack_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (cfg_pause) state_q <= StDrain;
        end
        StDrain: begin
          if (!cfg_pause) begin
            state_q <= StRun;
          end else if (drained) begin
            state_q     <= StPaused;
            pause_ack_q <= 1'b1;
          end
        end
        StPaused: begin
          if (!cfg_pause) begin
            state_q     <= StRun;
            pause_ack_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StRun;
          pause_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign lu_tuple       = lu_tuple_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_match      = rsp_match_q;
  assign rsp_port       = rsp_port_q;
  assign rsp_vport      = rsp_vport_q;
  assign rsp_type       = rsp_type_q;
  assign rsp_match_addr = rsp_match_addr_q;
  assign pause_ack      = pause_ack_q;
  assign err_unexpected = err_unexpected_q;
  assign err_missing    = err_missing_q;
  assign stat_issued    = stat_issued_q;

endmodule

// File: doc/lookup_scheduler.md
Name: lookup_scheduler

Overview:
- Shares one fixed-latency static lookup engine between C_NUM_REQ header-parser requesters, one per input port.
- Round-robin arbitration issues at most one tuple per cycle into the engine.
- Tracks requester IDs through the engine pipeline and steers each action back to the requester that issued the lookup.
- Provides a pause/drain handshake so the control path can quiesce lookups before reconfiguring forwarding.

Parameters:
- C_NUM_REQ, 6: number of requesters (1..8).
- C_LOOKUP_LATENCY, 1: cycles from lu_tuple.valid to the engine's action_valid (1..8).
- C_OUT_PORT_WIDTH, 8: width of action_port and action_vport.
- C_MATCH_ADDR_WIDTH, from parameters.v: width of the match address.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  C_NUM_REQ  per-requester tuple valid.
- req_ready  out  C_NUM_REQ  per-requester grant.
- req_tuple  in  C_NUM_REQ x tuple_t  per-requester tuple.
- lu_tuple  out  tuple_t  to engine; its .valid field is the issue strobe.
- lu_action_match  in  1  engine result.
- lu_action_valid  in  1  engine result.
- lu_action_port  in  C_OUT_PORT_WIDTH  engine result.
- lu_action_vport  in  C_OUT_PORT_WIDTH  engine result.
- lu_action_type  in  2  engine result.
- lu_action_match_addr  in  C_MATCH_ADDR_WIDTH  engine result.
- rsp_valid  out  C_NUM_REQ  one-hot response strobe.
- rsp_match, rsp_port, rsp_vport, rsp_type, rsp_match_addr  out  as lu_*  shared response bus.
- cfg_pause  in  1  request quiesce.
- pause_ack  out  1  engine idle, no grants.
- err_clear  in  1  clears sticky errors.
- err_unexpected  out  1  sticky: result arrived with no lookup in flight.
- err_missing  out  1  sticky: lookup in flight but no result arrived.
- stat_issued  out  32  lookups issued.

Behaviour:
- Reset (reset=0, asynchronous): clear all state.
  - Outputs 0: req_ready, lu_tuple (all fields, incl. .valid), rsp_*, pause_ack, err_*, stat_issued.
  - State = RUN; round-robin pointer = C_NUM_REQ-1; ID pipeline emptied.
  - Anything in flight is discarded; no response is emitted for it after reset releases.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - A requester holds req_valid and a stable req_tuple until its transfer.
  - req_ready is combinational from registered state and req_valid.
  - req_ready is one-hot or zero, and is nonzero only in RUN.
- Arbitration:
  - Grant goes to the first asserted req_valid scanning upward from pointer+1, wrapping modulo C_NUM_REQ.
  - On a transfer, the pointer becomes the granted index.
  - With no requests, the pointer holds.
  - A continuously valid requester is granted within C_NUM_REQ cycles.
- Issue:
  - The cycle after a transfer, lu_tuple = granted tuple with .valid=1. Otherwise lu_tuple.valid=0 and the other fields hold.
  - stat_issued increments on each issue and wraps at 2^32.
- ID tracking:
  - A shift register of depth C_LOOKUP_LATENCY of {valid, id}, loaded in step with lu_tuple.valid.
  - Its tail is aligned with lu_action_valid.
- Response, registered (one cycle after lu_action_valid):
  - Tail valid & lu_action_valid: rsp_valid[id]=1; rsp_* = lu_action_*.
  - Tail valid & !lu_action_valid: no response; err_missing set.
  - !Tail valid & lu_action_valid: result dropped; err_unexpected set.
  - Otherwise rsp_valid=0 and rsp_* fields hold.
  - Total latency from transfer to rsp_valid = C_LOOKUP_LATENCY+2 cycles.
  - Responses have no backpressure.
- Errors:
  - Sticky until err_clear=1.
  - A set and a clear in the same cycle: set wins.
- Pause FSM (states RUN, DRAIN, PAUSED):
  - RUN -> DRAIN on cfg_pause=1. req_ready=0 from that same cycle; the last transfer is the one taken in the cycle before.
  - DRAIN -> PAUSED when lu_tuple.valid=0, the ID pipeline is empty, and no response is pending.
  - DRAIN -> RUN if cfg_pause drops before then.
  - In PAUSED: pause_ack=1 (registered); no grants.
  - PAUSED -> RUN on cfg_pause=0; pause_ack drops in the same transition.
  - In-flight lookups always complete and respond during DRAIN.
- Simultaneous cycle events:
  - An issue and a response for different lookups in the same cycle are both handled.
  - A transfer in the cycle cfg_pause rises is impossible (ready already gated).

Test Plan:
- Single requester: req_valid[2]=1 tuple.port=2, L=1 -> req_ready[2] same cycle; lu_tuple.valid next cycle; rsp_valid=6'b000100 three cycles after the transfer, with the engine's port/vport.
- All six valid continuously from reset -> grants in order 0,1,2,3,4,5,0; each rsp_valid one-hot matches the issue order; stat_issued=7 after seven issues.
- Back-to-back with L=4: requesters 1 and 3 alternate every cycle -> the response stream alternates 1,3,1,3 with no gaps or mis-steering.
- cfg_pause=1 with 3 lookups in flight -> req_ready=0 immediately; three responses delivered; pause_ack=1 after the drain; clearing cfg_pause resumes grants from the saved pointer.
- Engine model injects lu_action_valid with nothing in flight -> err_unexpected=1, no rsp_valid. Suppressing one result -> err_missing=1. err_clear -> both 0.
- Assert reset with 2 lookups in flight -> all outputs 0 asynchronously; after release no stale rsp_valid; stat_issued=0.
